rgb_led_driver: RTL and testbench
=================================

Name: rgb_led_driver

Overview:
- Downstream stage of the 2-bit comparator, which produces one-hot R/G/B flags for a<b, a==b and a>b. This block consumes those flags and drives the board RGB LED.
- Registers the flags and validates that they are one-hot.
- Flashes the LED at full brightness for a fixed time whenever the result changes, then holds the colour PWM-dimmed.
- Flags invalid (non-one-hot) input.

Parameters:
- BW, 8, width of brightness input and PWM counter
- FLASH_LEN, 16, cycles of full-brightness flash after a colour change (>=1)

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- r_in  input  1  comparator R flag
- g_in  input  1  comparator G flag
- b_in  input  1  comparator B flag
- brightness  input  BW  steady-state PWM duty
- led_r  output  1  red LED drive
- led_g  output  1  green LED drive
- led_b  output  1  blue LED drive
- change_pulse  output  1  one-cycle pulse on accepted colour change
- err  output  1  high while registered input is not one-hot

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low. rst_n sampled low at a clk rising edge resets the block.
  - Reset clears: color_q=3'b000, prev_q=3'b000, pwm_cnt=0, flash_cnt=0, state=IDLE.
  - All outputs reset to 0: led_r/g/b=0, change_pulse=0, err=0.
  - Reset mid-flash aborts the flash. The first valid input after release is treated as a change.
- Input stage:
  - color_q <= {r_in,g_in,b_in} every cycle.
  - valid = color_q has exactly one bit set.
- PWM:
  - pwm_cnt is a free-running BW-bit counter that wraps 2^BW-1 -> 0.
  - pwm_on = (pwm_cnt < brightness), except brightness = all-ones gives pwm_on constantly 1.
  - brightness=0 gives 0% duty.
- FSM (state_t), evaluated on color_q:
  - IDLE: LEDs off.
    - valid -> FLASH: load flash_cnt=FLASH_LEN-1, prev_q<=color_q, pulse.
    - !valid and color_q!=0 -> ERROR.
  - FLASH: LEDs = prev_q, full on.
    - valid and color_q!=prev_q -> restart FLASH with the new colour and pulse.
    - !valid -> ERROR.
    - flash_cnt==0 -> STEADY.
    - otherwise decrement flash_cnt.
  - STEADY: LEDs = prev_q & {3{pwm_on}}.
    - valid change -> FLASH with pulse.
    - !valid -> ERROR.
  - ERROR: LEDs off, err=1.
    - valid -> FLASH with pulse. The change is always accepted, even if the colour equals the last prev_q.
    - all-zero input also stays in ERROR.
  - IDLE with all-zero input stays IDLE with err=0. All-zero counts as an error only after the first valid input.
- Timing:
  - LED outputs, err and change_pulse are registered.
  - An input set up before edge k is in color_q after edge k. State and outputs reflect it after edge k+1, i.e. 2-cycle latency.
  - change_pulse is high for exactly the one cycle following the transition edge.
- Flash length and boundaries:
  - Flash occupies exactly FLASH_LEN cycles of full-on output, then STEADY.
  - A change on the same edge that flash_cnt reaches 0: the change wins and the flash restarts.
  - Inputs toggling every cycle keep the block in FLASH, with one pulse per accepted change.

Decomposition:
- Package rgb_pkg:
  - typedef enum logic [1:0] state_t {IDLE, STEADY, FLASH, ERROR}
  - typedef logic [2:0] color_t
  - constants COLOR_R=3'b100, COLOR_G=3'b010, COLOR_B=3'b001, COLOR_OFF=3'b000
  - function is_onehot(color_t)
- Sub-module pwm_gen (BW): clk, rst_n, brightness -> pwm_on. It owns pwm_cnt and the all-ones special case.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with r_in=1 -> all outputs 0. Release with g_in=1 -> change_pulse high for one cycle 2 cycles later, led_g=1 for 16 cycles, then STEADY.
- PWM duty: FLASH_LEN=16, brightness=64, BW=8, steady green -> led_g high for exactly 64 of every 256 cycles. brightness=0 -> led_g always 0. brightness=255 -> led_g always 1.
- Mid-flash change: g_in=1; 5 cycles into the flash switch to b_in=1 -> second pulse, led_b full-on for 16 further cycles, led_g=0 from the same cycle.
- Invalid input: steady R, then r_in=g_in=1 -> err=1 and LEDs 0 after 2 cycles. Return to r_in only -> err=0, pulse, red flash of 16 cycles.
- Boundary collision: apply a new colour timed so it lands in color_q on the edge where flash_cnt==0 -> FLASH restarts with the new colour, no STEADY cycle.
- Reset mid-flash: rst_n=0 at flash cycle 8 -> outputs 0 next cycle. After release the same colour flashes again with a pulse.

Source files
------------

// File: rtl/rgb_led_driver_pkg.sv
// rgb_pkg: shared types and helpers for the RGB LED driver.
//   state_t    - driver FSM states
//   color_t    - {R,G,B} flag vector as produced by the upstream comparator
//   COLOR_*    - the three legal one-hot colours plus "off"
//   is_onehot  - true when exactly one colour flag is set
package rgb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEADY = 2'd1,
    FLASH  = 2'd2,
    ERROR  = 2'd3
  } state_t;

  typedef logic [2:0] color_t;

  localparam color_t COLOR_R   = 3'b100;
  localparam color_t COLOR_G   = 3'b010;
  localparam color_t COLOR_B   = 3'b001;
  localparam color_t COLOR_OFF = 3'b000;

  function automatic logic is_onehot(input color_t c);
    return (c == COLOR_R) || (c == COLOR_G) || (c == COLOR_B);
  endfunction

endpackage

// File: rtl/rgb_led_driver_pwm_gen.sv
// pwm_gen: free-running PWM reference for the steady-state LED dimming.
//   clk        - system clock
//   rst_n      - synchronous active-low reset (clears the counter)
//   brightness - duty cycle, in counts out of 2^BW
//   pwm_on     - high while the counter is below brightness; forced high
//                when brightness is all-ones so full scale is truly 100%
module pwm_gen #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW-1:0] brightness,
  output logic          pwm_on
);

  logic [BW-1:0] pwm_cnt_reg;

  // Wraps naturally from 2^BW-1 back to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + BW'(1);
    end
  end

  // A plain compare would top out at (2^BW-1)/2^BW duty, so all-ones
  // is treated as "always on".
  assign pwm_on = (&brightness) ? 1'b1 : (pwm_cnt_reg < brightness);

endmodule

// File: rtl/rgb_led_driver.sv
// rgb_led_driver: drives the board RGB LED from the comparator's one-hot
// R/G/B result flags.
//   clk, rst_n          - system clock, synchronous active-low reset
//   r_in, g_in, b_in    - comparator result flags (expected one-hot)
//   brightness          - steady-state PWM duty
//   led_r, led_g, led_b - registered LED drives
//   change_pulse        - one-cycle pulse when a new colour is accepted
//   err                 - high while the registered input is not one-hot
//                         (all-zero counts only after the first valid input)
// A new colour flashes at full brightness for FLASH_LEN cycles, then the
// colour is held PWM-dimmed. Input-to-output latency is two cycles.
module rgb_led_driver
  import rgb_pkg::*;
#(
  parameter int BW        = 8,
  parameter int FLASH_LEN = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r_in,
  input  logic          g_in,
  input  logic          b_in,
  input  logic [BW-1:0] brightness,
  output logic          led_r,
  output logic          led_g,
  output logic          led_b,
  output logic          change_pulse,
  output logic          err
);

  localparam int FW = (FLASH_LEN > 1) ? $clog2(FLASH_LEN) : 1;
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_LEN - 1);

  color_t        color_q;
  color_t        prev_q;
  state_t        state_reg;
  logic [FW-1:0] flash_cnt_reg;
  color_t        led_reg;
  logic          change_pulse_reg;
  logic          err_reg;

  logic   pwm_on;
  logic   valid;
  logic   accept_change;
  logic   go_error;
  color_t steady_led;

  pwm_gen #(.BW(BW)) u_pwm_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .brightness (brightness),
    .pwm_on     (pwm_on)
  );

  assign valid = is_onehot(color_q);

  // Leaving IDLE or ERROR always takes the new colour, even if it matches
  // the last one shown; in FLASH/STEADY only a genuine change counts.
  assign accept_change = valid &&
                         ((state_reg == IDLE) || (state_reg == ERROR) ||
                          (color_q != prev_q));

  // All-zero input is tolerated only before the first valid colour.
  assign go_error = !valid && !((state_reg == IDLE) && (color_q == COLOR_OFF));

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_steady
      assign steady_led[gi] = prev_q[gi] & pwm_on;
    end
  endgenerate

  // Priority: accepted change > error > per-state behaviour. Giving the
  // change precedence over flash_cnt==0 lets a colour arriving on the last
  // flash cycle restart the flash without a STEADY cycle in between.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      color_q          <= COLOR_OFF;
      prev_q           <= COLOR_OFF;
      state_reg        <= IDLE;
      flash_cnt_reg    <= '0;
      led_reg          <= COLOR_OFF;
      change_pulse_reg <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      color_q          <= {r_in, g_in, b_in};
      change_pulse_reg <= 1'b0;

      if (accept_change) begin
        state_reg        <= FLASH;
        flash_cnt_reg    <= FLASH_LOAD;
        prev_q           <= color_q;
        led_reg          <= color_q;
        change_pulse_reg <= 1'b1;
        err_reg          <= 1'b0;
      end else if (go_error) begin
        state_reg <= ERROR;
        led_reg   <= COLOR_OFF;
        err_reg   <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            led_reg <= COLOR_OFF;
            err_reg <= 1'b0;
          end
          FLASH: begin
            err_reg <= 1'b0;
            if (flash_cnt_reg == '0) begin
              state_reg <= STEADY;
              led_reg   <= steady_led;
            end else begin
              flash_cnt_reg <= flash_cnt_reg - FW'(1);
              led_reg       <= prev_q;
            end
          end
          STEADY: begin
            err_reg <= 1'b0;
            led_reg <= steady_led;
          end
          ERROR: begin
            led_reg <= COLOR_OFF;
            err_reg <= 1'b1;
          end
          default: begin
            state_reg <= IDLE;
            led_reg   <= COLOR_OFF;
            err_reg   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign led_r        = led_reg[2];
  assign led_g        = led_reg[1];
  assign led_b        = led_reg[0];
  assign change_pulse = change_pulse_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_rgb_led_driver.sv
// Directed testbench for rgb_led_driver (BW=8, FLASH_LEN=16).
module tb_rgb_led_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r_in, g_in, b_in;
  logic [7:0] brightness;
  logic       led_r, led_g, led_b;
  logic       change_pulse;
  logic       err;

  int tests_run    = 0;
  int tests_failed = 0;

  wire [2:0] leds = {led_r, led_g, led_b};

  rgb_led_driver #(.BW(8), .FLASH_LEN(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .r_in         (r_in),
    .g_in         (g_in),
    .b_in         (b_in),
    .brightness   (brightness),
    .led_r        (led_r),
    .led_g        (led_g),
    .led_b        (led_b),
    .change_pulse (change_pulse),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c);
    {r_in, g_in, b_in} = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    brightness = 8'd0;
    drive(3'b100);
    repeat (3) tick();
    tests_run++;
    if (leds !== 3'b000 || change_pulse !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: leds=%b pulse=%b err=%b, want 000/0/0", leds, change_pulse, err);
    end
    drive(3'b000);
    rst_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (err !== 1'b0 || leds !== 3'b000) begin
      tests_failed++;
      $display("FAIL idle_zero: err=%b leds=%b, want 0/000", err, leds);
    end
    drive(3'b010);
    tick();
    tests_run++;
    if (change_pulse !== 1'b0 || leds !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_latency1: pulse=%b leds=%b, want 0/000", change_pulse, leds);
    end
    tick();
    tests_run++;
    if (change_pulse !== 1'b1 || leds !== 3'b010) begin
      tests_failed++;
      $display("FAIL reset_first_pulse: pulse=%b leds=%b, want 1/010", change_pulse, leds);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      tests_run++;
      if (change_pulse !== 1'b0 || leds !== 3'b010) begin
        tests_failed++;
        $display("FAIL reset_flash_cycle%0d: pulse=%b leds=%b, want 0/010", i + 1, change_pulse, leds);
      end
    end
    tick();
    tests_run++;
    if (leds !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flash_end: leds=%b, want 000 (steady, brightness 0)", leds);
    end
  endtask

  task automatic test_pwm();
    logic [7:0] bvals [3] = '{8'd64, 8'd0, 8'd255};
    int         expect_on [3] = '{64, 0, 256};
    for (int k = 0; k < 3; k++) begin
      int on_cnt = 0;
      brightness = bvals[k];
      tick();
      repeat (256) begin
        tick();
        if (led_g === 1'b1) on_cnt++;
      end
      tests_run++;
      if (on_cnt != expect_on[k]) begin
        tests_failed++;
        $display("FAIL pwm_duty_b%0d: led_g high %0d of 256, want %0d", bvals[k], on_cnt, expect_on[k]);
      end
    end
    brightness = 8'd0;
  endtask

  task automatic test_mid_flash();
    brightness = 8'd0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(3'b010);
    tick();
    tick();
    tests_run++;
    if (change_pulse !== 1'b1 || leds !== 3'b010) begin
      tests_failed++;
      $display("FAIL mid_first_pulse: pulse=%b leds=%b, want 1/010", change_pulse, leds);
    end
    repeat (4) tick();
    drive(3'b001);
    tick();
    tests_run++;
    if (change_pulse !== 1'b0 || leds !== 3'b010) begin
      tests_failed++;
      $display("FAIL mid_before_switch: pulse=%b leds=%b, want 0/010", change_pulse, leds);
    end
    tick();
    tests_run++;
    if (change_pulse !== 1'b1 || leds !== 3'b001) begin
      tests_failed++;
      $display("FAIL mid_second_pulse: pulse=%b leds=%b, want 1/001", change_pulse, leds);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      tests_run++;
      if (change_pulse !== 1'b0 || leds !== 3'b001) begin
        tests_failed++;
        $display("FAIL mid_flash_cycle%0d: pulse=%b leds=%b, want 0/001", i + 1, change_pulse, leds);
      end
    end
    tick();
    tests_run++;
    if (leds !== 3'b000) begin
      tests_failed++;
      $display("FAIL mid_flash_end: leds=%b, want 000", leds);
    end
  endtask

  task automatic test_invalid();
    brightness = 8'd255;
    drive(3'b100);
    tick();
    tick();
    tests_run++;
    if (change_pulse !== 1'b1 || leds !== 3'b100) begin
      tests_failed++;
      $display("FAIL inv_red_pulse: pulse=%b leds=%b, want 1/100", change_pulse, leds);
    end
    repeat (16) tick();
    tests_run++;
    if (leds !== 3'b100 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL inv_red_steady: leds=%b err=%b, want 100/0", leds, err);
    end
    drive(3'b110);
    tick();
    tests_run++;
    if (err !== 1'b0 || leds !== 3'b100) begin
      tests_failed++;
      $display("FAIL inv_latency1: err=%b leds=%b, want 0/100", err, leds);
    end
    tick();
    tests_run++;
    if (err !== 1'b1 || leds !== 3'b000) begin
      tests_failed++;
      $display("FAIL inv_error: err=%b leds=%b, want 1/000", err, leds);
    end
    drive(3'b100);
    tick();
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL inv_hold: err=%b, want 1", err);
    end
    tick();
    tests_run++;
    if (err !== 1'b0 || change_pulse !== 1'b1 || leds !== 3'b100) begin
      tests_failed++;
      $display("FAIL inv_recover: err=%b pulse=%b leds=%b, want 0/1/100", err, change_pulse, leds);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      tests_run++;
      if (change_pulse !== 1'b0 || leds !== 3'b100) begin
        tests_failed++;
        $display("FAIL inv_flash_cycle%0d: pulse=%b leds=%b, want 0/100", i + 1, change_pulse, leds);
      end
    end
    tick();
    drive(3'b000);
    tick();
    tick();
    tests_run++;
    if (err !== 1'b1 || leds !== 3'b000) begin
      tests_failed++;
      $display("FAIL inv_zero_after_valid: err=%b leds=%b, want 1/000", err, leds);
    end
  endtask

  task automatic test_boundary();
    brightness = 8'd255;
    drive(3'b010);
    tick();
    tick();
    tests_run++;
    if (change_pulse !== 1'b1 || leds !== 3'b010 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL bnd_start: pulse=%b leds=%b err=%b, want 1/010/0", change_pulse, leds, err);
    end
    repeat (14) tick();
    drive(3'b001);
    tick();
    tests_run++;
    if (change_pulse !== 1'b0 || leds !== 3'b010) begin
      tests_failed++;
      $display("FAIL bnd_last_flash: pulse=%b leds=%b, want 0/010", change_pulse, leds);
    end
    tick();
    tests_run++;
    if (change_pulse !== 1'b1 || leds !== 3'b001) begin
      tests_failed++;
      $display("FAIL bnd_restart: pulse=%b leds=%b, want 1/001", change_pulse, leds);
    end
    repeat (15) tick();
    tests_run++;
    if (leds !== 3'b001) begin
      tests_failed++;
      $display("FAIL bnd_flash_hold: leds=%b, want 001", leds);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [8] = '{3'b100, 3'b010, 3'b100, 3'b010,
                            3'b001, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 8; i++) begin
      drive(seq[i]);
      tick();
      if (i >= 1) begin
        tests_run++;
        if (change_pulse !== 1'b1 || leds !== seq[i-1]) begin
          tests_failed++;
          $display("FAIL b2b_step%0d: pulse=%b leds=%b, want 1/%b", i, change_pulse, leds, seq[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_flash();
    tick();
    tests_run++;
    if (change_pulse !== 1'b1 || leds !== 3'b001) begin
      tests_failed++;
      $display("FAIL rmf_flash_start: pulse=%b leds=%b, want 1/001", change_pulse, leds);
    end
    repeat (7) tick();
    tests_run++;
    if (change_pulse !== 1'b0 || leds !== 3'b001) begin
      tests_failed++;
      $display("FAIL rmf_cycle8: pulse=%b leds=%b, want 0/001", change_pulse, leds);
    end
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (leds !== 3'b000 || change_pulse !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmf_reset: leds=%b pulse=%b err=%b, want 000/0/0", leds, change_pulse, err);
    end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (leds !== 3'b000 || change_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmf_release: leds=%b pulse=%b, want 000/0", leds, change_pulse);
    end
    tick();
    tests_run++;
    if (change_pulse !== 1'b1 || leds !== 3'b001) begin
      tests_failed++;
      $display("FAIL rmf_reflash: pulse=%b leds=%b, want 1/001", change_pulse, leds);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    brightness = 8'd0;
    drive(3'b000);
    test_reset();
    test_pwm();
    test_mid_flash();
    test_invalid();
    test_boundary();
    test_back_to_back();
    test_reset_mid_flash();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
